dram_arbiter: RTL

- Shares one 16x8 single-port distributed RAM (synchronous write, asynchronous read `spo`) between two requesters.
- Each requester uses a hold-until-ack handshake.
- Round-robin arbitration grants at most one access per cycle. The arbiter drives the RAM `a`, `d` and `we` pins and returns registered read data.
- Sits between the CPU-side/test-side masters and the DRAM instance in the lab memory subsystem.

---
 rtl/dram_pkg.sv | 16 +
 rtl/dram_arbiter_if.sv | 48 ++++
 rtl/dram_arbiter_rr_arb2.sv | 50 +++++
 rtl/dram_arbiter.sv | 87 ++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// Shared constants and helpers for the two-requester distributed-RAM arbiter.
// Requester indices double as the encoding of gnt_id and the priority pointer.
package dram_pkg;

   localparam int AW = 4;
   localparam int DW = 8;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   // Round-robin hand-off: the requester not just served gets priority next.
   function automatic logic other_req(input logic id);
      return ~id;
   endfunction

endpackage

// File: rtl/dram_arbiter_if.sv
// Requester handshakes, RAM pins and grant status of the arbiter, bundled.
// slave = arbiter side; master = requesters plus the RAM instance.
interface dram_arbiter_if #(
   parameter int AW = dram_pkg::AW,
   parameter int DW = dram_pkg::DW
);

   logic          req0;
   logic          we0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] wdata0;
   logic          ack0;
   logic [DW-1:0] rdata0;

   logic          req1;
   logic          we1;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata1;
   logic          ack1;
   logic [DW-1:0] rdata1;

   logic [AW-1:0] ram_a;
   logic [DW-1:0] ram_d;
   logic          ram_we;
   logic [DW-1:0] ram_spo;

   logic          gnt_id;
   logic          gnt_vld;

   modport slave (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      input  ram_spo,
      output ack0, rdata0, ack1, rdata1,
      output ram_a, ram_d, ram_we,
      output gnt_id, gnt_vld
   );

   modport master (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      output ram_spo,
      input  ack0, rdata0, ack1, rdata1,
      input  ram_a, ram_d, ram_we,
      input  gnt_id, gnt_vld
   );

endinterface

// File: rtl/dram_arbiter_rr_arb2.sv
// Two-input round-robin grant: combinational winner, registered priority pointer.
// A single eligible requester always wins; on a conflict the pointer decides.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] elig,
   input  logic       advance,
   output logic       gnt_vld,
   output logic       gnt_id
);
   import dram_pkg::*;

   logic ptr;

   // NOTE: every output gets a default before the case so no path leaves
   // it unassigned; otherwise synthesis infers a latch.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = REQ0;
      unique case (elig)
         2'b01: begin
            gnt_vld = 1'b1;
            gnt_id  = REQ0;
         end
         2'b10: begin
            gnt_vld = 1'b1;
            gnt_id  = REQ1;
         end
         2'b11: begin
            gnt_vld = 1'b1;
            gnt_id  = ptr;
         end
         default: begin
            gnt_vld = 1'b0;
            gnt_id  = REQ0;
         end
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr <= REQ0;
      end else if (advance && gnt_vld) begin
         ptr <= other_req(gnt_id);
      end
   end

endmodule

// File: rtl/dram_arbiter.sv
// Shares one single-port distributed RAM between two hold-until-ack requesters.
// Drives the RAM pins from the round-robin winner and registers ack/read data.
module dram_arbiter #(
   parameter int AW = dram_pkg::AW,
   parameter int DW = dram_pkg::DW
) (
   input logic           clk,
   input logic           rst,
   dram_arbiter_if.slave bus
);
   import dram_pkg::*;

   logic [1:0]    elig;
   logic          gnt_vld;
   logic          gnt_id;
   logic          ack0_q;
   logic          ack1_q;
   logic [DW-1:0] rdata0_q;
   logic [DW-1:0] rdata1_q;
   logic          win_we;
   logic [AW-1:0] win_addr;
   logic [DW-1:0] win_wdata;

   // A requester sitting in its ack cycle is masked so a held command is not
   // serviced a second time.
   assign elig = {bus.req1 & ~ack1_q, bus.req0 & ~ack0_q};

   // Every issued grant is consumed in the same cycle, so the pointer always advances.
   rr_arb2 u_arb (
      .clk     (clk),
      .rst     (rst),
      .elig    (elig),
      .advance (1'b1),
      .gnt_vld (gnt_vld),
      .gnt_id  (gnt_id)
   );

   always_comb begin
      win_we    = 1'b0;
      win_addr  = '0;
      win_wdata = '0;
      if (gnt_vld) begin
         if (gnt_id == REQ1) begin
            win_we    = bus.we1;
            win_addr  = bus.addr1;
            win_wdata = bus.wdata1;
         end else begin
            win_we    = bus.we0;
            win_addr  = bus.addr0;
            win_wdata = bus.wdata0;
         end
      end
   end

   // The RAM write port is gated by rst directly, as the RAM itself never sees reset.
   assign bus.ram_a   = win_addr;
   assign bus.ram_d   = win_wdata;
   assign bus.ram_we  = gnt_vld & win_we & ~rst;
   assign bus.gnt_vld = gnt_vld;
   assign bus.gnt_id  = gnt_id;

   always_ff @(posedge clk) begin
      if (rst) begin
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
      end else begin
         ack0_q <= gnt_vld & (gnt_id == REQ0);
         ack1_q <= gnt_vld & (gnt_id == REQ1);
         // Writes leave the previous read data in place.
         if (gnt_vld && !win_we) begin
            if (gnt_id == REQ1) begin
               rdata1_q <= bus.ram_spo;
            end else begin
               rdata0_q <= bus.ram_spo;
            end
         end
      end
   end

   assign bus.ack0   = ack0_q;
   assign bus.ack1   = ack1_q;
   assign bus.rdata0 = rdata0_q;
   assign bus.rdata1 = rdata1_q;

endmodule
